// File: rtl/ddfs_pkg.sv
// ----------------------------------------------------------------------------
// ddfs_pkg
// Shared types and constants for the DDFS phase accumulator slice.
//
// Contents
//   cfg_state_t   configuration FSM state (IDLE / ARMED)
//   angle_90()    +90 degree angle code for a given angle width
//   angle_180()   -180 degree angle code for a given angle width
//   LFSR_MASK     Galois feedback mask of the 16-bit dither LFSR
//   LFSR_SEED     reset / clear seed of the dither LFSR
// ----------------------------------------------------------------------------
package ddfs_pkg;

   // IDLE : cfg_ready_o=1, a new config may be accepted.
   // ARMED: a synchronous config waits in the shadow registers for the
   //        next accumulator wrap.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } cfg_state_t;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // A full turn is 2^w, so a quarter turn sets bit w-2 and a half turn
   // sets bit w-1 (the sign bit, i.e. -180 degrees).
   function automatic logic [31:0] angle_90(input int unsigned w);
      return 32'd1 << (w - 2);
   endfunction

   function automatic logic [31:0] angle_180(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/ddfs_phase_accumulator_if.sv
// ----------------------------------------------------------------------------
// ddfs_phase_accumulator_if
// Bundles the control, configuration and angle-output signals of the DDFS
// phase accumulator.
//
// Handshake: a configuration transfer happens on a rising clk edge where
// cfg_valid_i and cfg_ready_o are both 1. The requester holds cfg_valid_i,
// cfg_sync_i, fcw_i and pofs_i stable until that edge; cfg_ready_o does not
// depend combinationally on cfg_valid_i.
//
// Signals
//   enable_i        advance accumulator and emit one sample this cycle
//   clear_i         synchronous accumulator clear
//   cfg_valid_i     config request
//   cfg_ready_o     config accept
//   cfg_sync_i      0 = apply immediately, 1 = apply at next accumulator wrap
//   fcw_i           frequency control word (ACC_WIDTH, unsigned)
//   pofs_i          phase offset (WIDTH, mod 2^WIDTH)
//   angle_o         signed angle to the CORDIC
//   angle_valid_o   angle_o holds a new sample
//   wrap_o          angle_o is the first sample after an accumulator wrap
//   cordic_valid_o  angle_valid_o delayed by the CORDIC latency
//   cfg_state_o     debug view of the configuration FSM state
//
// Modports: master drives the requests, slave is the accumulator itself.
// ----------------------------------------------------------------------------
interface ddfs_phase_accumulator_if #(
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned WIDTH     = 16
);
   import ddfs_pkg::*;

   logic                 enable_i;
   logic                 clear_i;
   logic                 cfg_valid_i;
   logic                 cfg_ready_o;
   logic                 cfg_sync_i;
   logic [ACC_WIDTH-1:0] fcw_i;
   logic [WIDTH-1:0]     pofs_i;
   logic [WIDTH-1:0]     angle_o;
   logic                 angle_valid_o;
   logic                 wrap_o;
   logic                 cordic_valid_o;
   cfg_state_t           cfg_state_o;

   modport master (
      output enable_i, clear_i, cfg_valid_i, cfg_sync_i, fcw_i, pofs_i,
      input  cfg_ready_o, angle_o, angle_valid_o, wrap_o, cordic_valid_o,
             cfg_state_o
   );

   modport slave (
      input  enable_i, clear_i, cfg_valid_i, cfg_sync_i, fcw_i, pofs_i,
      output cfg_ready_o, angle_o, angle_valid_o, wrap_o, cordic_valid_o,
             cfg_state_o
   );

endinterface

// File: rtl/ddfs_phase_accumulator_lfsr.sv
// ----------------------------------------------------------------------------
// ddfs_lfsr
// 16-bit right-shifting Galois LFSR used to dither the phase truncation.
// Only instantiated when DDFS_PHASE_DITHER_EN is defined.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset (loads LFSR_SEED)
//   step_i    advance one step this edge
//   reseed_i  load LFSR_SEED this edge (priority over step_i)
//   state_o   current LFSR state
// ----------------------------------------------------------------------------
module ddfs_lfsr
   import ddfs_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_i,
   input  logic        reseed_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LFSR_SEED;
      end else if (reseed_i) begin
         state_q <= LFSR_SEED;
      end else if (step_i) begin
         // The bit shifted out feeds back into the tap positions of the mask.
         state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_MASK : 16'h0000);
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/ddfs_phase_accumulator.sv
// ----------------------------------------------------------------------------
// ddfs_phase_accumulator
// Phase generator feeding the CORDIC sine/cosine engine. Integrates a
// frequency control word into an ACC_WIDTH-bit accumulator, adds a phase
// offset and truncates to a WIDTH-bit signed angle (full scale = one turn).
// A sample-valid is delayed by CORDIC_LAT cycles to qualify the CORDIC result.
//
// Optional feature: define DDFS_PHASE_DITHER_EN to add LFSR dither below the
// truncation point (output path only). Without it, truncation is plain.
//
// Parameters
//   ACC_WIDTH    accumulator / FCW width (>= WIDTH)
//   WIDTH        angle width
//   CORDIC_LAT   CORDIC latency in cycles (>= 2)
//   DITHER_BITS  dither bits injected when dithering (<= ACC_WIDTH-WIDTH)
//
// Ports
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     ddfs_phase_accumulator_if.slave (control, config, angle outputs)
// ----------------------------------------------------------------------------
module ddfs_phase_accumulator
   import ddfs_pkg::*;
#(
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned CORDIC_LAT  = 17,
   parameter int unsigned DITHER_BITS = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   ddfs_phase_accumulator_if.slave  bus
);

   // Parameter sanity checks at elaboration time.
   if (ACC_WIDTH < WIDTH) begin : g_chk_acc_width
      $error("ddfs_phase_accumulator: ACC_WIDTH must be >= WIDTH");
   end
   if (DITHER_BITS > ACC_WIDTH - WIDTH) begin : g_chk_dither_bits
      $error("ddfs_phase_accumulator: DITHER_BITS must be <= ACC_WIDTH-WIDTH");
   end
   if (CORDIC_LAT < 2) begin : g_chk_latency
      $error("ddfs_phase_accumulator: CORDIC_LAT must be >= 2");
   end

   // Accumulator and output registers
   logic [ACC_WIDTH-1:0]  acc_q;
   logic                  carry_q;
   logic [WIDTH-1:0]      angle_q;
   logic                  valid_q;
   logic                  wrap_q;

   // Configuration: active values, shadow values and FSM
   logic [ACC_WIDTH-1:0]  fcw_act_q;
   logic [WIDTH-1:0]      pofs_act_q;
   logic [ACC_WIDTH-1:0]  fcw_shd_q;
   logic [WIDTH-1:0]      pofs_shd_q;
   cfg_state_t            state_q;
   logic                  ready_q;

   // CORDIC valid delay line
   logic [CORDIC_LAT-1:0] dline_q;

   // Combinational helpers
   logic [ACC_WIDTH:0]    acc_sum;
   logic                  cfg_accept;
   logic                  wrap_now;
   logic [WIDTH-1:0]      trunc_w;

   // One bit wider than the accumulator so the carry-out marks the wrap.
   assign acc_sum    = {1'b0, acc_q} + {1'b0, fcw_act_q};
   assign cfg_accept = bus.cfg_valid_i & ready_q;
   assign wrap_now   = bus.enable_i & acc_sum[ACC_WIDTH];

`ifdef DDFS_PHASE_DITHER_EN
   logic [15:0]                  lfsr_w;
   logic [WIDTH+DITHER_BITS-1:0] dith_sum;

   // The LFSR advances with every sample and restarts from its seed on a
   // clear, so a cleared generator reproduces the same dithered sequence.
   ddfs_lfsr u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_i   (bus.enable_i & ~bus.clear_i),
      .reseed_i (bus.clear_i),
      .state_o  (lfsr_w)
   );

   // Dither lands just below the truncation point; a carry out of the dither
   // add rounds the angle up by one LSB. acc_q itself is never disturbed.
   assign dith_sum = acc_q[ACC_WIDTH-1 -: WIDTH+DITHER_BITS]
                   + {{WIDTH{1'b0}}, lfsr_w[DITHER_BITS-1:0]};
   assign trunc_w  = dith_sum[WIDTH+DITHER_BITS-1 -: WIDTH];
`else
   assign trunc_w  = acc_q[ACC_WIDTH-1 -: WIDTH];
`endif

   // ------------------------------------------------------------------------
   // Accumulator and sample output.
   // The angle is formed from the accumulator value *before* this edge's
   // increment, so the first sample after a clear equals the phase offset.
   // wrap_o reports the carry produced by the previous increment, which makes
   // it coincide with the first angle sample taken after the wrap.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         angle_q <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (bus.clear_i) begin
         // Clear wins over enable; angle_o keeps its last value.
         acc_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (bus.enable_i) begin
         acc_q   <= acc_sum[ACC_WIDTH-1:0];
         carry_q <= acc_sum[ACC_WIDTH];
         angle_q <= trunc_w + pofs_act_q;
         valid_q <= 1'b1;
         wrap_q  <= carry_q;
      end else begin
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Configuration FSM with registered cfg_ready_o.
   // Active values loaded on an edge take effect from the next increment,
   // because this edge's sum and angle already used the old values.
   // A clear forces any pending or simultaneous config to apply at once so
   // the restarted waveform begins with the new settings.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         fcw_act_q  <= '0;
         pofs_act_q <= '0;
         fcw_shd_q  <= '0;
         pofs_shd_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_accept) begin
                  if (bus.cfg_sync_i && !bus.clear_i) begin
                     fcw_shd_q  <= bus.fcw_i;
                     pofs_shd_q <= bus.pofs_i;
                     state_q    <= ARMED;
                     ready_q    <= 1'b0;
                  end else begin
                     fcw_act_q  <= bus.fcw_i;
                     pofs_act_q <= bus.pofs_i;
                  end
               end
            end
            ARMED: begin
               if (bus.clear_i || wrap_now) begin
                  fcw_act_q  <= fcw_shd_q;
                  pofs_act_q <= pofs_shd_q;
                  state_q    <= IDLE;
                  ready_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Valid delay line matching the CORDIC pipeline. Only rst_n clears it:
   // a clear must not drop samples already inside the CORDIC.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dline_q <= '0;
      end else begin
         dline_q <= {dline_q[CORDIC_LAT-2:0], valid_q};
      end
   end

   assign bus.angle_o        = angle_q;
   assign bus.angle_valid_o  = valid_q;
   assign bus.wrap_o         = wrap_q;
   assign bus.cfg_ready_o    = ready_q;
   assign bus.cordic_valid_o = dline_q[CORDIC_LAT-1];
   assign bus.cfg_state_o    = state_q;

endmodule
